systolic_array_stream: RTL and testbench

Streaming, parametrised successor to the fixed-format matrix multiplier top level. It multiplies two N×N matrices of DATA_W-bit elements on an N×N systolic PE array and produces ACC_W-bit results. It adds valid/ready handshakes on input and output, optional signed arithmetic, and a result holding register, so the next job can be accepted while the previous result waits for the consumer. It sits between a matrix-fetch producer and a result-writeback consumer.

---
 rtl/systolic_array_stream_pkg.sv | 19 +
 rtl/systolic_array_stream_if.sv | 24 ++
 rtl/systolic_array_stream_pe.sv | 53 +++++
 rtl/systolic_array_stream.sv | 158 +++++++++++++++
 tb/tb_systolic_array_stream.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_array_stream_pkg.sv
// Shared types and elaboration helpers for the streaming systolic matrix multiplier.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Cycles needed for the last skewed operand pair to reach the far-corner PE.
  function automatic int mult_cycles(input int n);
    return 3 * n - 2;
  endfunction

  function automatic bit acc_w_ok(input int n, input int data_w, input int acc_w);
    return acc_w >= 2 * data_w + $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_array_stream_if.sv
// Job/result handshake bundle between the matrix-fetch producer, the array and the writeback consumer.
interface systolic_array_stream_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);
  logic [N-1:0][N-1:0][DATA_W-1:0] i_a;
  logic [N-1:0][N-1:0][DATA_W-1:0] i_b;
  logic                            i_valid;
  logic                            o_ready;
  logic [N-1:0][N-1:0][ACC_W-1:0]  o_c;
  logic                            o_valid;
  logic                            i_ready;

  modport slave (
    input  i_a, i_b, i_valid, i_ready,
    output o_ready, o_c, o_valid
  );

  modport master (
    output i_a, i_b, i_valid, i_ready,
    input  o_ready, o_c, o_valid
  );
endinterface

// File: rtl/systolic_array_stream_pe.sv
// One multiply-accumulate cell: forwards a right and b down, accumulates a*b modulo 2^ACC_W.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 0
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [ACC_W-1:0]  o_acc
);
  localparam int PW  = 2 * DATA_W;
  localparam bit SGN = (SIGNED != 0);

  logic [PW-1:0]     a_ext, b_ext, prod;
  logic [ACC_W-1:0]  prod_ext, acc_q, acc_d;
  logic [DATA_W-1:0] a_q, b_q;

  assign a_ext    = {{DATA_W{SGN & i_a[DATA_W-1]}}, i_a};
  assign b_ext    = {{DATA_W{SGN & i_b[DATA_W-1]}}, i_b};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W-PW){SGN & prod[PW-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (i_clr)     acc_d = '0;
    else if (i_en) acc_d = acc_q + prod_ext;
  end

  always_ff @(posedge i_clk) begin
    if (i_arst || i_clr) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (i_en) begin
      a_q   <= i_a;
      b_q   <= i_b;
      acc_q <= acc_d;
    end
  end

  assign o_a   = a_q;
  assign o_b   = b_q;
  // Next-state value, so the result register can capture the final product on the last RUN edge.
  assign o_acc = acc_d;
endmodule

// File: rtl/systolic_array_stream.sv
// Streaming N x N systolic matrix multiplier with valid/ready job input and a held result slot.
module systolic_array_stream
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 0
) (
  input logic                     i_clk,
  input logic                     i_arst,
  systolic_array_stream_if.slave  bus
);
  if (N < 2 || N > 255) begin : g_bad_n
    $error("systolic_array_stream: N=%0d outside 2..255", N);
  end
  if (!acc_w_ok(N, DATA_W, ACC_W)) begin : g_bad_acc
    $error("systolic_array_stream: ACC_W=%0d too narrow for DATA_W=%0d, N=%0d", ACC_W, DATA_W, N);
  end

  localparam int MC     = mult_cycles(N);
  localparam int CNT_W  = $clog2(MC);
  localparam int SR_LEN = 2 * N - 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready, accept, pe_en, pe_clr, load, last_run, slot_free;
  logic              o_valid_q, o_valid_d;

  logic [N-1:0][SR_LEN-1:0][DATA_W-1:0] row_q, row_d, col_q, col_d;
  logic [N-1:0][N:0][DATA_W-1:0]        a_w;
  logic [N:0][N-1:0][DATA_W-1:0]        b_w;
  logic [N-1:0][N-1:0][ACC_W-1:0]       acc_w, c_q, c_d;
  logic [N-1:0]                         unused_a, unused_b;

  assign last_run  = (cnt_q == CNT_W'(MC - 1));
  assign slot_free = !o_valid_q || bus.i_ready;

  always_ff @(posedge i_clk) begin
    if (i_arst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_valid) state_d = RUN;
      RUN:     if (last_run) state_d = slot_free ? IDLE : DRAIN;
      DRAIN:   if (o_valid_q && bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready  = 1'b0;
    accept = 1'b0;
    pe_en  = 1'b0;
    pe_clr = 1'b0;
    load   = 1'b0;
    case (state_q)
      IDLE: begin
        ready  = 1'b1;
        accept = bus.i_valid;
        pe_clr = bus.i_valid;
      end
      RUN: begin
        pe_en = 1'b1;
        load  = last_run && slot_free;
      end
      DRAIN:   load = o_valid_q && bus.i_ready;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept)                 cnt_d = '0;
    else if (pe_en && !last_run) cnt_d = cnt_q + CNT_W'(1);
  end

  // Lane gi holds row gi of A and column gi of B, pre-skewed by gi leading zeros.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    for (genvar gp = 0; gp < SR_LEN; gp++) begin : g_tap
      logic [DATA_W-1:0] row_ld, row_sh, col_ld, col_sh;
      if (gp >= gi && gp < gi + N) begin : g_data
        assign row_ld = bus.i_a[gi][gp-gi];
        assign col_ld = bus.i_b[gp-gi][gi];
      end else begin : g_pad
        assign row_ld = '0;
        assign col_ld = '0;
      end
      if (gp < SR_LEN - 1) begin : g_mid
        assign row_sh = row_q[gi][gp+1];
        assign col_sh = col_q[gi][gp+1];
      end else begin : g_end
        assign row_sh = '0;
        assign col_sh = '0;
      end
      assign row_d[gi][gp] = accept ? row_ld : (pe_en ? row_sh : row_q[gi][gp]);
      assign col_d[gi][gp] = accept ? col_ld : (pe_en ? col_sh : col_q[gi][gp]);
    end
    assign a_w[gi][0] = row_q[gi][0];
    assign b_w[0][gi] = col_q[gi][0];
    assign unused_a[gi] = ^a_w[gi][N];
    assign unused_b[gi] = ^b_w[N][gi];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      systolic_pe #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .SIGNED(SIGNED)
      ) u_pe (
        .i_clk (i_clk),
        .i_arst(i_arst),
        .i_en  (pe_en),
        .i_clr (pe_clr),
        .i_a   (a_w[gi][gj]),
        .i_b   (b_w[gi][gj]),
        .o_a   (a_w[gi][gj+1]),
        .o_b   (b_w[gi+1][gj]),
        .o_acc (acc_w[gi][gj])
      );
    end
  end

  always_comb begin
    c_d       = c_q;
    o_valid_d = o_valid_q;
    if (load) begin
      c_d       = acc_w;
      o_valid_d = 1'b1;
    end else if (bus.i_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      c_q       <= '0;
      o_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      c_q       <= c_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_c     = c_q;
  assign bus.o_valid = o_valid_q;
endmodule

// File: tb/tb_systolic_array_stream.sv
// Drives an unsigned and a signed instance with identical jobs and checks both against a plain matrix-product model.
module tb_systolic_array_stream;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int MC = 3 * N - 2;
  localparam int NV = 4;

  typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;
  typedef logic [N-1:0][N-1:0][AW-1:0] res_t;
  typedef struct {
    string name;
    mat_t  a;
    mat_t  b;
    res_t  exp_u;
    res_t  exp_s;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  mat_t a_in, b_in;
  logic valid_in, ready_in;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  systolic_array_stream_if #(.N(N), .DATA_W(DW), .ACC_W(AW)) bus_u ();
  systolic_array_stream_if #(.N(N), .DATA_W(DW), .ACC_W(AW)) bus_s ();

  assign bus_u.i_a = a_in;   assign bus_s.i_a = a_in;
  assign bus_u.i_b = b_in;   assign bus_s.i_b = b_in;
  assign bus_u.i_valid = valid_in;  assign bus_s.i_valid = valid_in;
  assign bus_u.i_ready = ready_in;  assign bus_s.i_ready = ready_in;

  systolic_array_stream #(.N(N), .DATA_W(DW), .ACC_W(AW), .SIGNED(0)) u_dut_u (
    .i_clk(clk), .i_arst(rst), .bus(bus_u.slave)
  );
  systolic_array_stream #(.N(N), .DATA_W(DW), .ACC_W(AW), .SIGNED(1)) u_dut_s (
    .i_clk(clk), .i_arst(rst), .bus(bus_s.slave)
  );

  function automatic res_t model(input mat_t a, input mat_t b, input bit sgn);
    res_t r;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        longint s;
        s = 0;
        for (int k = 0; k < N; k++) begin
          longint x, y;
          if (sgn) begin
            x = longint'($signed(a[i][k]));
            y = longint'($signed(b[k][j]));
          end else begin
            x = longint'(a[i][k]);
            y = longint'(b[k][j]);
          end
          s = s + x * y;
        end
        r[i][j] = s[31:0];
      end
    end
    return r;
  endfunction

  function automatic mat_t const_mat(input logic [DW-1:0] v);
    mat_t m;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic res_t const_res(input logic [AW-1:0] v);
    res_t m;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic mat_t diag(input logic [DW-1:0] v);
    mat_t m;
    m = '0;
    for (int i = 0; i < N; i++) m[i][i] = v;
    return m;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m[i][j] = DW'($urandom);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_mat(input string name, input res_t act, input res_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = N - 1; i >= 0; i--)
        for (int j = N - 1; j >= 0; j--)
          if (act[i][j] !== exp[i][j]) begin
            $display("FAIL %s: c[%0d][%0d] got %0h expected %0h", name, i, j, act[i][j], exp[i][j]);
            i = -1;
            break;
          end
    end
  endtask

  task automatic check_pair(input string name, input res_t eu, input res_t es);
    chk_mat({name, "_c_u"}, bus_u.o_c, eu);
    chk_mat({name, "_c_s"}, bus_s.o_c, es);
  endtask

  task automatic accept(input mat_t a, input mat_t b);
    a_in = a;
    b_in = b;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  // Full job with a free output slot; hold keeps i_valid high with other data during RUN.
  task automatic run_job(input string name, input mat_t a, input mat_t b,
                         input res_t eu, input res_t es, input bit hold);
    int n, lat, low;
    ready_in = 1'b1;
    n = 0;
    while (!(bus_u.o_ready && !bus_u.o_valid) && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_idle"}, {62'd0, bus_u.o_ready, bus_u.o_valid}, 64'd2);
    a_in = a;
    b_in = b;
    valid_in = 1'b1;
    tick();
    if (hold) begin
      a_in = rand_mat();
      b_in = rand_mat();
    end else begin
      valid_in = 1'b0;
    end
    lat = 1;
    low = 0;
    while (!bus_u.o_valid && lat < 100) begin
      if (!bus_u.o_ready) low++;
      if (lat == MC) valid_in = 1'b0;
      tick();
      lat++;
    end
    valid_in = 1'b0;
    chk({name, "_latency"}, 64'(lat), 64'(3 * N - 1));
    chk({name, "_ready_low_cycles"}, 64'(low), 64'(MC));
    chk({name, "_ready_back"}, 64'(bus_u.o_ready), 64'd1);
    chk({name, "_valid_s"}, 64'(bus_s.o_valid), 64'd1);
    check_pair(name, eu, es);
    $display("job %-14s lat=%0d c00=%0h/%0h c33=%0h/%0h", name, lat,
             bus_u.o_c[0][0], bus_s.o_c[0][0], bus_u.o_c[N-1][N-1], bus_s.o_c[N-1][N-1]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[NV];
    mat_t ra, rb, rc, rd;
    res_t two_i;

    vecs[0].name = "ident_x_b";
    vecs[0].a    = diag(8'd1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        vecs[0].b[i][j]     = DW'(4 * i + j);
        vecs[0].exp_u[i][j] = AW'(4 * i + j);
        vecs[0].exp_s[i][j] = AW'(4 * i + j);
      end
    vecs[1] = '{"all_255", const_mat(8'hFF), const_mat(8'hFF), const_res(32'd260100), const_res(32'd4)};
    vecs[2] = '{"all_0x80", const_mat(8'h80), const_mat(8'h80), const_res(32'd65536), const_res(32'd65536)};
    vecs[3] = '{"neg1_x_1", const_mat(8'hFF), const_mat(8'h01), const_res(32'd1020), const_res(32'hFFFFFFFC)};
    two_i = '0;
    for (int i = 0; i < N; i++) two_i[i][i] = 32'd2;

    rst = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_ready_u", 64'(bus_u.o_ready), 64'd1);
    chk("reset_valid_u", 64'(bus_u.o_valid), 64'd0);
    chk("reset_valid_s", 64'(bus_s.o_valid), 64'd0);
    check_pair("reset", '0, '0);

    for (int v = 0; v < NV; v++)
      run_job(vecs[v].name, vecs[v].a, vecs[v].b, vecs[v].exp_u, vecs[v].exp_s, 1'b0);

    for (int r = 0; r < 6; r++) begin
      ra = rand_mat();
      rb = rand_mat();
      run_job($sformatf("rand%0d", r), ra, rb, model(ra, rb, 1'b0), model(ra, rb, 1'b1), 1'b0);
    end

    ra = rand_mat();
    rb = rand_mat();
    run_job("hold_valid", ra, rb, model(ra, rb, 1'b0), model(ra, rb, 1'b1), 1'b1);

    // Backpressure: second job finishes while the first result is still unconsumed.
    tick();
    ready_in = 1'b0;
    accept(diag(8'd1), diag(8'd2));
    repeat (MC) tick();
    chk("bp_job1_valid", 64'(bus_u.o_valid), 64'd1);
    check_pair("bp_job1", two_i, two_i);
    ra = rand_mat();
    rb = rand_mat();
    accept(ra, rb);
    repeat (MC) tick();
    chk("bp_drain_ready", 64'(bus_u.o_ready), 64'd0);
    chk("bp_drain_valid", 64'(bus_u.o_valid), 64'd1);
    check_pair("bp_drain_hold", two_i, two_i);
    repeat (3) tick();
    chk("bp_drain_ready_later", 64'(bus_s.o_ready), 64'd0);
    check_pair("bp_drain_hold_later", two_i, two_i);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    chk("bp_release_valid", 64'(bus_u.o_valid), 64'd1);
    chk("bp_release_ready", 64'(bus_u.o_ready), 64'd1);
    check_pair("bp_job2", model(ra, rb, 1'b0), model(ra, rb, 1'b1));
    $display("job %-14s released after drain", "backpressure");
    ready_in = 1'b1;
    tick();
    chk("bp_consumed_valid", 64'(bus_u.o_valid), 64'd0);

    // Reset at RUN counter 5 with an older result still held in the slot.
    ready_in = 1'b0;
    accept(rand_mat(), rand_mat());
    repeat (MC) tick();
    chk("rst_held_valid", 64'(bus_u.o_valid), 64'd1);
    rc = rand_mat();
    rd = rand_mat();
    accept(rc, rd);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid_u", 64'(bus_u.o_valid), 64'd0);
    chk("rst_mid_valid_s", 64'(bus_s.o_valid), 64'd0);
    chk("rst_mid_ready_u", 64'(bus_u.o_ready), 64'd1);
    chk("rst_mid_ready_s", 64'(bus_s.o_ready), 64'd1);
    check_pair("rst_mid", '0, '0);
    $display("job %-14s aborted by reset", "reset_mid_run");
    ra = rand_mat();
    rb = rand_mat();
    run_job("after_reset", ra, rb, model(ra, rb, 1'b0), model(ra, rb, 1'b1), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
